// File: rtl/ed25519_pkg.sv
// Shared constants and types for the field-element encoding datapath.
// Optional build macro FE_TOBYTES_STREAM_EN adds the STREAM state.
package ed25519_pkg;

  localparam int LIMB_W = 32;
  localparam int ACC_W  = 64;
  localparam int NLIMB  = 10;

  // Radix-2^25.5 limb widths and bit offsets within the 255-bit value.
  localparam int LIMB_BITS [NLIMB] = '{26, 25, 26, 25, 26, 25, 26, 25, 26, 25};
  localparam int LIMB_OFS  [NLIMB] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};

  // p = 2^255 - 19
  localparam logic [255:0] P_255_19 = {1'b0, {247{1'b1}}, 8'hED};

`ifdef FE_TOBYTES_STREAM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_QCHAIN, ST_FOLD, ST_CARRY, ST_PACK, ST_STREAM, ST_DONE
  } fe_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_QCHAIN, ST_FOLD, ST_CARRY, ST_PACK, ST_DONE
  } fe_state_e;
`endif

endpackage

// File: rtl/fe_limb_step.sv
// One limb step: adds an incoming quotient/carry to a limb, then splits the
// sum into the arithmetic-shifted quotient and the non-negative remainder.
module fe_limb_step
  import ed25519_pkg::*;
(
  input  logic signed [ACC_W-1:0] val_i,
  input  logic signed [ACC_W-1:0] add_i,
  input  logic                    odd_i,
  output logic signed [ACC_W-1:0] quo_o,
  output logic signed [ACC_W-1:0] rem_o
);

  logic signed [ACC_W-1:0] sum;
  logic [5:0]              w;

  assign sum   = val_i + add_i;
  assign w     = odd_i ? 6'(LIMB_BITS[1]) : 6'(LIMB_BITS[0]);
  assign quo_o = sum >>> w;
  // Shift left on the unsigned view so a negative quotient does not overflow.
  assign rem_o = sum - signed'(unsigned'(quo_o) << w);

endmodule

// File: rtl/fe_tobytes.sv
// Field element (10 signed limbs, radix 2^25.5) to canonical 32-byte
// little-endian encoding mod 2^255-19.
// Optional build macro FE_TOBYTES_STREAM_EN adds a byte-serial output port.
//
// state  | meaning
// IDLE   | waiting for start; latch limbs and seed q from h9
// QCHAIN | 10 cycles propagating q to find floor(value / p)
// FOLD   | add 19*q into limb 0
// CARRY  | 10 cycles normalising limbs to [0, 2^w)
// PACK   | concatenate limbs into s
// STREAM | (optional) emit s byte by byte
// DONE   | result valid until start is low
module fe_tobytes
  import ed25519_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NLIMB*LIMB_W-1:0]   h,
  output logic [255:0]              s,
  output logic                      busy,
  output logic                      done
`ifdef FE_TOBYTES_STREAM_EN
  ,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready
`endif
);

  fe_state_e               state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] q_q, q_d;
  logic signed [ACC_W-1:0] h_q [NLIMB];
  logic signed [ACC_W-1:0] h_d [NLIMB];
  logic [255:0]            s_q, s_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef FE_TOBYTES_STREAM_EN
  logic [4:0]              bcnt_q, bcnt_d;
`endif

  logic signed [ACC_W-1:0] step_add, step_quo, step_rem;
  logic signed [ACC_W-1:0] h9_ext;
  logic [255:0]            pack_w;

  assign step_add = (state_q == ST_QCHAIN) ? q_q : '0;
  assign h9_ext   = ACC_W'(signed'(h[9*LIMB_W +: LIMB_W]));

  fe_limb_step u_step (
    .val_i (h_q[idx_q]),
    .add_i (step_add),
    .odd_i (idx_q[0]),
    .quo_o (step_quo),
    .rem_o (step_rem)
  );

  // Pack the low LIMB_BITS[i] bits of each normalised limb; bit 255 stays 0.
  always_comb begin
    pack_w = '0;
    for (int i = 0; i < NLIMB; i++)
      for (int b = 0; b < 26; b++)
        if (b < LIMB_BITS[i]) pack_w[LIMB_OFS[i] + b] = h_q[i][b];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    q_d     = q_q;
    h_d     = h_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef FE_TOBYTES_STREAM_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          for (int i = 0; i < NLIMB; i++)
            h_d[i] = ACC_W'(signed'(h[i*LIMB_W +: LIMB_W]));
          q_d     = (h9_ext * 64'sd19 + 64'sd16777216) >>> 25;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_QCHAIN;
        end
      end
      ST_QCHAIN: begin
        q_d = step_quo;
        if (idx_q == 4'd9) begin
          idx_d   = '0;
          state_d = ST_FOLD;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_FOLD: begin
        h_d[0]  = h_q[0] + q_q * 64'sd19;
        state_d = ST_CARRY;
      end
      ST_CARRY: begin
        h_d[idx_q] = step_rem;
        if (idx_q == 4'd9) begin
          idx_d   = '0;
          state_d = ST_PACK;
        end else begin
          h_d[idx_q + 4'd1] = h_q[idx_q + 4'd1] + step_quo;
          idx_d = idx_q + 4'd1;
        end
      end
      ST_PACK: begin
        s_d = pack_w;
`ifdef FE_TOBYTES_STREAM_EN
        bcnt_d  = '0;
        state_d = ST_STREAM;
`else
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
`endif
      end
`ifdef FE_TOBYTES_STREAM_EN
      ST_STREAM: begin
        if (out_ready) begin
          if (bcnt_q == 5'd31) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            bcnt_d = bcnt_q + 5'd1;
          end
        end
      end
`endif
      ST_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      q_q     <= '0;
      for (int i = 0; i < NLIMB; i++) h_q[i] <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FE_TOBYTES_STREAM_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      h_q     <= h_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FE_TOBYTES_STREAM_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign s    = s_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef FE_TOBYTES_STREAM_EN
  assign out_valid = (state_q == ST_STREAM);
  assign out_byte  = s_q[{bcnt_q, 3'b000} +: 8];
`endif

endmodule

// File: tb/tb_fe_tobytes.sv
// Directed and randomised checks of fe_tobytes against constants and a
// wide-integer value-mod-p model.
module tb_fe_tobytes;
  import ed25519_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [319:0] h;
  logic [255:0] s;
  logic         busy, done;
`ifdef FE_TOBYTES_STREAM_EN
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   got_bytes[$];
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int lv [10];

  always #5 clk = ~clk;

  fe_tobytes dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .h     (h),
    .s     (s),
    .busy  (busy),
    .done  (done)
`ifdef FE_TOBYTES_STREAM_EN
    ,
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] pk(input int a [10]);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = a[i];
    return r;
  endfunction

  // value = sum h_i * 2^ofs_i, offset by 16p so it is non-negative, then mod p
  function automatic logic [255:0] golden(input logic [319:0] hv);
    logic [319:0]        acc;
    logic signed [319:0] t;
    acc = 320'(P_255_19) << 4;
    for (int i = 0; i < 10; i++) begin
      t   = signed'(hv[i*32 +: 32]);
      acc = acc + (t << LIMB_OFS[i]);
    end
    return 256'(acc % 320'(P_255_19));
  endfunction

`ifdef FE_TOBYTES_STREAM_EN
  // Random backpressure; record bytes that will handshake at the next edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = ($urandom_range(1, 0) == 1);
      if (out_valid && out_ready) got_bytes.push_back(out_byte);
    end
  end
`endif

  task automatic run_conv(input string tag, input logic [319:0] hv,
                          input logic [255:0] exp, input bit full);
    int lat;
    int bsy_err;
    lat = 0;
    bsy_err = 0;
`ifdef FE_TOBYTES_STREAM_EN
    got_bytes.delete();
`endif
    @(negedge clk);
    h = hv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done && lat < 600) begin
      @(posedge clk);
      #1 lat++;
      if (!done && !busy) bsy_err++;
    end
    check(tag, s, exp);
    if (full) begin
      check({tag, "_busy_lo"}, 256'(busy), 256'd0);
      check({tag, "_busy_hi"}, 256'(bsy_err), 256'd0);
`ifdef FE_TOBYTES_STREAM_EN
      begin
        logic [255:0] bs;
        bs = '0;
        for (int k = 0; k < got_bytes.size() && k < 32; k++) bs[8*k +: 8] = got_bytes[k];
        check({tag, "_nbytes"}, 256'(got_bytes.size()), 256'd32);
        check({tag, "_stream"}, bs, exp);
      end
`else
      check({tag, "_lat"}, 256'(lat), 256'd22);
`endif
    end
    @(posedge clk);
    #1;
    if (full) check({tag, "_done_drop"}, 256'(done), 256'd0);
  endtask

  initial begin
    logic [255:0] exp_pm1;
    reset = 1'b1;
    start = 1'b0;
    h = '0;
    repeat (3) @(negedge clk);
    check("rst_s", s, 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    reset = 1'b0;

    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_conv("zero", pk(lv), 256'd0, 1'b1);

    lv = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_conv("one", pk(lv), 256'd1, 1'b1);

    lv = '{32'h3FFFFED, 32'h1FFFFFF, 32'h3FFFFFF, 32'h1FFFFFF, 32'h3FFFFFF,
           32'h1FFFFFF, 32'h3FFFFFF, 32'h1FFFFFF, 32'h3FFFFFF, 32'h1FFFFFF};
    run_conv("p", pk(lv), 256'd0, 1'b1);

    lv[0] = 32'h3FFFFEE;
    run_conv("p_plus1", pk(lv), 256'd1, 1'b1);

    exp_pm1 = {8'h7F, {30{8'hFF}}, 8'hEC};
    lv = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_conv("neg1", pk(lv), exp_pm1, 1'b1);

    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2000000};
    run_conv("two255", pk(lv), 256'd19, 1'b1);

    // reset 10 cycles into a conversion clears s and done immediately
    lv = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    h = pk(lv);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_s", s, 256'd0);
    check("midrst_done", 256'(done), 256'd0);
    check("midrst_busy", 256'(busy), 256'd0);
    @(negedge clk);
    reset = 1'b0;

    // start re-pulsed with different limbs while busy is ignored
    begin
      int lat;
      lat = 0;
      lv = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      @(negedge clk);
      h = pk(lv);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) begin
        @(posedge clk);
        #1 lat++;
      end
      @(negedge clk);
      lv = '{9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2000000};
      h = pk(lv);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
      while (!done && lat < 600) begin
        @(posedge clk);
        #1 lat++;
      end
      check("repulse_s", s, 256'd5);
`ifndef FE_TOBYTES_STREAM_EN
      check("repulse_lat", 256'(lat), 256'd22);
`endif
      @(posedge clk);
      #1;
    end

    // random limbs, |h| < 2^26
    for (int n = 0; n < 1000; n++) begin
      logic [319:0] hv;
      for (int i = 0; i < 10; i++)
        lv[i] = int'($urandom_range(32'h7FFFFFE, 0)) - 32'sh3FFFFFF;
      hv = pk(lv);
      run_conv("rand", hv, golden(hv), (n < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fe_tobytes.md
Name: fe_tobytes

Overview:
- Converts a signed 10-limb radix-2^25.5 field element (limbs such as the squarer/multiplier outputs) into the canonical 32-byte little-endian encoding of the value mod p = 2^255-19.
- This is the output/encoding end of the field-arithmetic datapath. It feeds point compression and signature serialisation.
- Sequential design: one shared 64-bit adder/shifter runs a quotient chain, a 19*q fold, a carry chain, then a pack.

Parameters:
- LIMB_W, 32, width of each signed input limb.
- ACC_W, 64, width of the internal signed limb accumulators and the q register.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- h  in  320  signed limbs. Limb i is at h[32i+31:32i]. Each |limb| <= 2^26·1.5.
- s  out  256  canonical encoding. Byte k is at s[8k+7:8k]. Bit 255 is always 0.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  result valid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, s=0, done=0, busy=0, all limb registers and q cleared. Reset mid-operation aborts the conversion, and no partial s is ever exposed.
- States: IDLE -> QCHAIN -> FOLD -> CARRY -> PACK -> DONE.
- IDLE:
  - done=0.
  - On start: latch h into H[0..9] (sign-extended to ACC_W).
  - Compute q <= (19·h9 + 2^24) >>> 25 directly from the port.
  - Set idx=0 and go to QCHAIN.
- QCHAIN, 10 cycles, idx 0..9:
  - q <= (H[idx] + q) >>> w(idx), where w = 26 for even idx and 25 for odd idx.
  - After idx=9, go to FOLD.
- FOLD, 1 cycle: H[0] <= H[0] + 19·q. At this point q ∈ {0,1}.
- CARRY, 10 cycles, idx 0..9:
  - c = H[idx] >>> w(idx).
  - H[idx] <= H[idx] - (c << w(idx)).
  - For idx<9: H[idx+1] <= H[idx+1] + c.
  - For idx=9: the carry is discarded (no wrap to H[0]).
- PACK, 1 cycle:
  - s <= concatenation of the low w(i) bits of each H[i], at bit offsets 0, 26, 51, 77, 102, 128, 153, 179, 204, 230. Bit 255 is 0.
  - done <= 1 and busy <= 0.
- DONE: done stays high while start is high. When start is low, go to IDLE and done drops on the next edge. s holds its value until the next PACK.
- Latency: start is sampled on edge E, and done is visible after edge E+22.
- start asserted while busy is ignored.
- A back-to-back request needs start to be low for at least one cycle in DONE.
- All shifts are arithmetic on signed ACC_W values. The left shift is done on the unsigned reinterpretation to avoid signed-overflow warnings.
- Non-canonical inputs in [p, 2^255+δ) and negative limbs must reduce to the unique representative in [0, p).

Optional Feature:
- Macro FE_TOBYTES_STREAM_EN.
- When defined:
  - Adds ports out_byte[7:0] out, out_valid out, out_ready in.
  - PACK goes to a STREAM state that emits s bytes 0..31, LSB first. A byte advances on out_valid&&out_ready, and out_byte/out_valid stay stable while stalled.
  - DONE (done=1) is entered only after byte 31 handshakes. The parallel s is still valid.
  - Reset clears the byte counter and out_valid.
- When undefined: no stream ports and no STREAM state. Timing is as above.

Decomposition:
- Shared package ed25519_pkg, holding:
  - LIMB_W and ACC_W.
  - The limb width table LIMB_BITS = {26,25,26,25,26,25,26,25,26,25}.
  - The limb offset table LIMB_OFS.
  - The constant P_255_19.
  - The state enum type.
- One natural sub-module: fe_limb_step, a combinational unit.
  - Inputs: limb value, incoming q/carry and width select.
  - Outputs: the shifted quotient and the remainder limb.
  - Shared by QCHAIN and CARRY.

Test Plan:
- All limbs 0 -> s=0. done after exactly 22 cycles. busy high for cycles 1..21.
- h0=1, others 0 -> s=256'h1.
- p in limbs (h0=0x3FFFFED, odd limbs 0x1FFFFFF, even limbs 0x3FFFFFF) -> s=0. p+1 (h0=0x3FFFFEE) -> s=1.
- h0=-1 (0xFFFFFFFF), others 0 -> s=2^255-20, i.e. s[7:0]=8'hEC, bytes 1..30 = 8'hFF, byte 31 = 8'h7F.
- h9=0x2000000, others 0 (value 2^255) -> s=19. Then random limbs with |h|<2^26 checked against a golden model of value mod p over 1000 vectors.
- Reset asserted at cycle 10 of a conversion -> done=0, s=0 immediately. start re-pulsed mid-busy -> ignored. Under FE_TOBYTES_STREAM_EN, out_ready toggled randomly -> 32 bytes equal s in order, and done rises only after byte 31.
